// File: rtl/tick_gen_multi.sv
`default_nettype none
// ============================================================================
// Module  : tick_gen_multi
// Brief   : NCH-channel programmable 1-cycle pulse timer, periodic or one-shot.
//           Optional macro TICK_ACCEL_EN shortens the period after each pulse.
// Revision: 1.0
// ============================================================================
module tick_gen_multi #(
  parameter int          NCH            = 4,
  parameter int          WIDTH          = 31,
  parameter int unsigned DEFAULT_PERIOD = 500_000,
  parameter int unsigned ACCEL_STEP     = 1_000,
  parameter int unsigned MIN_PERIOD     = 100_000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NCH-1:0]                       en,
  input  logic [NCH-1:0]                       start,
  input  logic                                 cfg_wr,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]                     cfg_period,
  input  logic                                 cfg_oneshot,
  output logic [NCH-1:0]                       pulse,
  output logic [NCH-1:0]                       running,
  output logic [NCH*WIDTH-1:0]                 period_q
);

`ifdef TICK_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  localparam int               WP1     = WIDTH + 1;
  localparam logic [WIDTH-1:0] DEF_P   = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] STEP_P  = WIDTH'(ACCEL_STEP);
  localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH:0]   MIN_X   = WP1'(MIN_PERIOD);
  localparam logic [WIDTH:0]   FLOOR_X = WP1'(MIN_PERIOD + ACCEL_STEP);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Periods already below the floor are left untouched.
  function automatic logic [WIDTH-1:0] accel_period(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] px;
    px = {1'b0, p};
    if (px > FLOOR_X)
      accel_period = p - STEP_P;
    else if (px >= MIN_X)
      accel_period = MIN_P;
    else
      accel_period = p;
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] period, period_nxt;
    logic             oneshot, oneshot_nxt;
    state_t           state, state_nxt;
    logic             cfg_sel;
    logic             due;

    assign cfg_sel = cfg_wr && (int'(cfg_ch) == i);
    assign due     = (state == S_RUN) && en[i] && (cnt == period);

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt     <= '0;
        period  <= DEF_P;
        oneshot <= 1'b0;
        state   <= S_RUN;
      end else begin
        cnt     <= cnt_nxt;
        period  <= period_nxt;
        oneshot <= oneshot_nxt;
        state   <= state_nxt;
      end
    end

    always_comb begin
      cnt_nxt     = cnt;
      period_nxt  = period;
      oneshot_nxt = oneshot;
      state_nxt   = state;
      if (cfg_sel) begin
        period_nxt  = cfg_period;
        oneshot_nxt = cfg_oneshot;
        cnt_nxt     = '0;
        state_nxt   = S_RUN;
      end else if (start[i]) begin
        cnt_nxt   = '0;
        state_nxt = S_RUN;
      end else if (state == S_RUN && en[i]) begin
        if (cnt == period) begin
          cnt_nxt = '0;
          if (oneshot)
            state_nxt = S_IDLE;
          if (ACCEL_ON)
            period_nxt = accel_period(period);
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end
    end

    // A restart or reconfiguration in the due cycle swallows that pulse.
    assign pulse[i]                      = due && !cfg_sel && !start[i] && !reset;
    assign running[i]                    = reset || (state == S_RUN);
    assign period_q[i*WIDTH +: WIDTH]    = period;
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_gen_multi.sv
`default_nettype none
// Bench for tick_gen_multi: directed literal scenarios, then randomized
// traffic compared every cycle against a behavioural model.
module tb_tick_gen_multi;
  localparam int NCH   = 3;
  localparam int WIDTH = 8;
  localparam int DEFP  = 4;
  localparam int STEP  = 3;
  localparam int MINP  = 5;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NCH-1:0]         en;
  logic [NCH-1:0]         start;
  logic                   cfg_wr;
  logic [1:0]             cfg_ch;
  logic [WIDTH-1:0]       cfg_period;
  logic                   cfg_oneshot;
  logic [NCH-1:0]         pulse;
  logic [NCH-1:0]         running;
  logic [NCH*WIDTH-1:0]   period_q;

  int vectors     = 0;
  int miscompares = 0;

  // Model: enabled cycles since last (re)arm, period, mode, armed flag.
  int n   [NCH];
  int per [NCH];
  bit os  [NCH];
  bit arm [NCH];
  logic [NCH-1:0] exp_pulse;

  tick_gen_multi #(
    .NCH(NCH), .WIDTH(WIDTH), .DEFAULT_PERIOD(DEFP),
    .ACCEL_STEP(STEP), .MIN_PERIOD(MINP)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .start(start),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_oneshot(cfg_oneshot), .pulse(pulse), .running(running),
    .period_q(period_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit hit(input int ch);
    return cfg_wr && (int'(cfg_ch) == ch);
  endfunction

  function automatic int accel(input int p);
`ifdef TICK_ACCEL_EN
    if (p < MINP) return p;
    if (p - STEP < MINP) return MINP;
    return p - STEP;
`else
    return p;
`endif
  endfunction

  task automatic settle_and_check();
    logic [NCH-1:0]       er;
    logic [NCH*WIDTH-1:0] ep;
    #1;
    for (int i = 0; i < NCH; i++) begin
      exp_pulse[i] = !reset && arm[i] && en[i] && (n[i] == per[i]) && !start[i] && !hit(i);
      er[i] = reset || arm[i];
      ep[i*WIDTH +: WIDTH] = WIDTH'(per[i]);
    end
    chk("pulse", 32'(pulse), 32'(exp_pulse));
    chk("running", 32'(running), 32'(er));
    chk("period_q", 32'(period_q), 32'(ep));
  endtask

  task automatic advance();
    @(posedge clock);
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        n[i] = 0; per[i] = DEFP; os[i] = 1'b0; arm[i] = 1'b1;
      end else if (hit(i)) begin
        n[i] = 0; per[i] = int'(cfg_period); os[i] = cfg_oneshot; arm[i] = 1'b1;
      end else if (start[i]) begin
        n[i] = 0; arm[i] = 1'b1;
      end else if (arm[i] && en[i]) begin
        if (n[i] == per[i]) begin
          n[i] = 0;
          if (os[i]) arm[i] = 1'b0;
          per[i] = accel(per[i]);
        end else begin
          n[i]++;
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int seq [3];
    int pc;
    bit pending;
`ifdef TICK_ACCEL_EN
    seq[0] = 7;  seq[1] = 5;  seq[2] = 5;
`else
    seq[0] = 10; seq[1] = 10; seq[2] = 10;
`endif
    for (int i = 0; i < NCH; i++) begin
      n[i] = 0; per[i] = 0; os[i] = 1'b0; arm[i] = 1'b0;
    end
    reset = 1'b1; en = '1; start = '0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;

    @(negedge clock);
    advance();
    settle_and_check();
    chk("reset_pulse", 32'(pulse), 32'h0);
    chk("reset_running", 32'(running), 32'h7);
    chk("reset_period", 32'(period_q), 32'h040404);
    advance();

    // Free-running from reset release: ticks at cycles 4, 9, 14.
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      settle_and_check();
      chk("free_run_pulse", 32'(pulse), (k == 4 || k == 9 || k == 14) ? 32'h7 : 32'h0);
      advance();
    end

    // One-shot on ch1 with period 2, then re-arm with start.
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_period = 8'd2; cfg_oneshot = 1'b1;
    settle_and_check();
    advance();
    cfg_wr = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      settle_and_check();
      chk("oneshot_pulse1", 32'(pulse[1]), (j == 3) ? 32'h1 : 32'h0);
      if (j >= 4) chk("oneshot_idle1", 32'(running[1]), 32'h0);
      advance();
    end
    start[1] = 1'b1;
    settle_and_check();
    advance();
    start[1] = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      settle_and_check();
      chk("restart_pulse1", 32'(pulse[1]), (j == 3) ? 32'h1 : 32'h0);
      if (j == 1) chk("restart_running1", 32'(running[1]), 32'h1);
      advance();
    end

    // Period evolution on ch2 from 10 over successive pulses.
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd10; cfg_oneshot = 1'b0;
    settle_and_check();
    advance();
    cfg_wr = 1'b0;
    pc = 0; pending = 1'b0;
    for (int c = 0; c < 40; c++) begin
      settle_and_check();
      if (c == 0) chk("accel_initial", 32'(period_q[2*WIDTH +: WIDTH]), 32'd10);
      if (pending) begin
        chk("accel_period", 32'(period_q[2*WIDTH +: WIDTH]), 32'(seq[pc]));
        pc++;
        pending = 1'b0;
      end
      if (exp_pulse[2] && pc < 3) pending = 1'b1;
      advance();
    end
    chk("accel_pulse_count", 32'(pc), 32'd3);

    // Randomized traffic including out-of-range cfg_ch, period 0 and resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NCH; i++) begin
        en[i]    = ($urandom_range(0, 7) != 0);
        start[i] = ($urandom_range(0, 19) == 0);
      end
      cfg_wr      = ($urandom_range(0, 14) == 0);
      cfg_ch      = 2'($urandom_range(0, 3));
      cfg_period  = 8'($urandom_range(0, 12));
      cfg_oneshot = 1'($urandom_range(0, 1));
      settle_and_check();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
